// File: rtl/cntr8_driver.sv
// ============================================================================
// Module   : cntr8_driver
// Brief    : Command-side controller for the 8-bit load/inc counter. It loads
//            the counter, steps it toward a target, then parks it there.
//            Optional macro CNTR8_DRV_STEP_CNT_EN adds the steps_o port.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cntr8_driver #(
    parameter int CNT_LAT = 2,
    parameter int TIMEOUT = 511
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [7:0] start_val_i,
    input  logic [7:0] target_i,
    input  logic [7:0] cnt_i,
    output logic       load_o,
    output logic       inc_o,
    output logic [7:0] d_out_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
`ifdef CNTR8_DRV_STEP_CNT_EN
    ,
    output logic [8:0] steps_o
`endif
);

    localparam int LCW = $clog2(CNT_LAT + 2);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       sv_q, sv_d;
    logic [7:0]       tg_q, tg_d;
    logic             dir_q, dir_d;
    logic [7:0]       park_q, park_d;
    logic [LCW-1:0]   lcnt_q, lcnt_d;
    logic [8:0]       step_q, step_d;
    logic             err_q, err_d;

    logic             load_q, load_d;
    logic             inc_q, inc_d;
    logic [7:0]       dout_q, dout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             w_hit;

    // Counter output lags the controls, so passing the target also ends the run.
    assign w_hit = (cnt_i == tg_q)
                || ( dir_q && (cnt_i > tg_q))
                || (!dir_q && (cnt_i < tg_q));

    always_comb begin
        state_d = state_q;
        sv_d    = sv_q;
        tg_d    = tg_q;
        dir_d   = dir_q;
        park_d  = park_q;
        lcnt_d  = lcnt_q;
        step_d  = step_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    sv_d    = start_val_i;
                    tg_d    = target_i;
                    dir_d   = (target_i > start_val_i);
                    err_d   = 1'b0;
                    lcnt_d  = '0;
                    step_d  = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (lcnt_q == LCW'(CNT_LAT)) begin
                    state_d = (sv_q == tg_q) ? S_DONE : S_RUN;
                end else begin
                    lcnt_d = lcnt_q + LCW'(1);
                end
            end
            S_RUN: begin
                step_d = step_q + 9'd1;
                if (w_hit) begin
                    state_d = S_DONE;
                end else if (step_d == 9'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_DONE: begin
                park_d  = tg_q;
                state_d = S_IDLE;
            end
            S_ERR: begin
                park_d  = sv_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        load_d = 1'b1;
        inc_d  = 1'b0;
        dout_d = park_d;
        busy_d = 1'b0;
        done_d = 1'b0;

        case (state_d)
            S_LOAD: begin
                dout_d = sv_d;
                busy_d = 1'b1;
            end
            S_RUN: begin
                load_d = 1'b0;
                inc_d  = dir_d;
                dout_d = sv_d;
                busy_d = 1'b1;
            end
            S_DONE: begin
                dout_d = tg_d;
                done_d = 1'b1;
            end
            S_ERR: begin
                dout_d = sv_d;
            end
            default: begin
                dout_d = park_d;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            sv_q    <= '0;
            tg_q    <= '0;
            dir_q   <= 1'b0;
            park_q  <= '0;
            lcnt_q  <= '0;
            step_q  <= '0;
            err_q   <= 1'b0;
            load_q  <= 1'b1;
            inc_q   <= 1'b0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sv_q    <= sv_d;
            tg_q    <= tg_d;
            dir_q   <= dir_d;
            park_q  <= park_d;
            lcnt_q  <= lcnt_d;
            step_q  <= step_d;
            err_q   <= err_d;
            load_q  <= load_d;
            inc_q   <= inc_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef CNTR8_DRV_STEP_CNT_EN
    logic [8:0] steps_q, steps_d;

    always_comb begin
        steps_d = steps_q;
        if ((state_q == S_LOAD || state_q == S_RUN) &&
            (state_d == S_DONE || state_d == S_ERR)) begin
            steps_d = step_d;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            steps_q <= '0;
        end else begin
            steps_q <= steps_d;
        end
    end

    assign steps_o = steps_q;
`endif

    assign load_o  = load_q;
    assign inc_o   = inc_q;
    assign d_out_o = dout_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign err_o   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_cntr8_driver.sv
// ============================================================================
// Module   : tb_cntr8_driver
// Brief    : Directed bench for cntr8_driver with a behavioural 2-cycle cntr8.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cntr8_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] start_val = 8'd0;
    logic [7:0] target = 8'd0;
    logic [7:0] cnt;
    logic       load, inc, busy, done, err;
    logic [7:0] d_out;
`ifdef CNTR8_DRV_STEP_CNT_EN
    logic [8:0] steps;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int n_done = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    // Behavioural counter: controls registered once, then applied: 2-cycle latency.
    logic       m_load_r = 1'b1;
    logic       m_inc_r  = 1'b0;
    logic [7:0] m_d_r    = 8'd0;
    logic [7:0] m_cnt    = 8'd0;
    logic       stuck    = 1'b0;

    always @(posedge clk) begin
        m_load_r <= load;
        m_inc_r  <= inc;
        m_d_r    <= d_out;
        m_cnt    <= m_load_r ? m_d_r : (m_inc_r ? m_cnt + 8'd1 : m_cnt - 8'd1);
    end

    assign cnt = stuck ? 8'd0 : m_cnt;

    always #5 clk = ~clk;

    always @(negedge clk) if (done) n_done++;

    cntr8_driver #(.CNT_LAT(2), .TIMEOUT(511)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .start_val_i (start_val),
        .target_i    (target),
        .cnt_i       (cnt),
        .load_o      (load),
        .inc_o       (inc),
        .d_out_o     (d_out),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
`ifdef CNTR8_DRV_STEP_CNT_EN
        ,
        .steps_o     (steps)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Drives a one-cycle start; returns at the negedge after it was sampled.
    task automatic do_start(input logic [7:0] sv, input logic [7:0] tg, input logic [7:0] expv);
        @(negedge clk);
        start     = 1'b1;
        start_val = sv;
        target    = tg;
        exp_q.push_back(expv);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int n;
        n = 0;
        while (!done && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1);
        if (done && exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            chk("done_dout", d_out, exp_v);
            chk("done_busy", busy, 0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int d0;

        // 1. reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_load", load, 1);
        chk("rst_dout", d_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cnt", cnt, 0);
`ifdef CNTR8_DRV_STEP_CNT_EN
        chk("rst_steps", steps, 0);
`endif
        reset = 1'b0;
        idle(2);

        // 2. count up 10 -> 20
        d0 = n_done;
        do_start(8'd10, 8'd20, 8'd20);
        for (int i = 0; i < 3; i++) begin
            chk("up_load_phase", load, 1);
            chk("up_load_dout", d_out, 10);
            chk("up_load_busy", busy, 1);
            @(negedge clk);
        end
        chk("up_run_load", load, 0);
        chk("up_run_inc", inc, 1);
        wait_done(100);
        idle(4);
        for (int i = 0; i < 50; i++) begin
            chk("up_park_cnt", cnt, 20);
            @(negedge clk);
        end
        chk("up_done_pulses", n_done - d0, 1);

        // 3. count down 200 -> 5
        do_start(8'd200, 8'd5, 8'd5);
        idle(3);
        chk("dn_run_load", load, 0);
        chk("dn_run_inc", inc, 0);
        wait_done(400);
        idle(5);
        chk("dn_final_cnt", cnt, 5);

        // 4. start value equals target
        do_start(8'd77, 8'd77, 8'd77);
        for (int i = 0; i < 3; i++) begin
            chk("eq_done_early", done, 0);
            chk("eq_busy", busy, 1);
            @(negedge clk);
        end
        chk("eq_done_at4", done, 1);
        wait_done(1);
`ifdef CNTR8_DRV_STEP_CNT_EN
        chk("eq_steps", steps, 0);
`endif
        idle(5);
        chk("eq_final_cnt", cnt, 77);

        // 5. stuck counter -> timeout after 511 RUN cycles
        stuck = 1'b1;
        d0 = n_done;
        do_start(8'd30, 8'd100, 8'd30);
        idle(513);
        chk("to_err_before", err, 0);
        chk("to_busy_before", busy, 1);
        @(negedge clk);
        chk("to_err", err, 1);
        chk("to_busy", busy, 0);
        chk("to_load", load, 1);
        exp_v = exp_q.pop_front();
        chk("to_dout", d_out, exp_v);
`ifdef CNTR8_DRV_STEP_CNT_EN
        chk("to_steps", steps, 511);
`endif
        stuck = 1'b0;
        idle(5);
        chk("to_park_cnt", cnt, 30);
        chk("to_err_sticky", err, 1);
        chk("to_no_done", n_done - d0, 0);
        do_start(8'd5, 8'd5, 8'd5);
        chk("to_err_clear", err, 0);
        wait_done(10);

        // 6a. second start ignored while busy
        idle(3);
        do_start(8'd10, 8'd20, 8'd20);
        start     = 1'b1;
        start_val = 8'd99;
        target    = 8'd50;
        @(negedge clk);
        start = 1'b0;
        chk("ign_busy", busy, 1);
        wait_done(100);
        idle(5);
        chk("ign_cnt", cnt, 20);

        // 6b. asynchronous reset mid-RUN
        do_start(8'd0, 8'd200, 8'd200);
        idle(10);
        chk("mid_run_load", load, 0);
        #2 reset = 1'b1;
        #1;
        chk("arst_load", load, 1);
        chk("arst_inc", inc, 0);
        chk("arst_dout", d_out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_err", err, 0);
        exp_q.delete();
        idle(2);
        reset = 1'b0;
        idle(4);
        chk("arst_cnt_park", cnt, 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
